bp_cache_fill_responder: RTL and testbench
==========================================

BP_CACHE_FILL_RESPONDER -- requirements
Module: bp_cache_fill_responder

Interface
REQ-001 Parameters SHALL be: paddr_width_p, default 40, physical address width.
REQ-002 Parameters SHALL be: sets_p, default 64, cache sets; assoc_p, default 8, ways; block_width_p, default 512, fill block width.
REQ-003 Derived widths SHALL be: index_w = log2(sets_p); way_w = log2(assoc_p); offset_w = log2(block_width_p/8); tag_w = paddr_width_p-index_w-offset_w.
REQ-004 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Ports SHALL be:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- cache_req_v_i  in  1  request valid.
- cache_req_yumi_o  out  1  request accepted.
- cache_req_type_i  in  3  0 miss_load, 1 miss_store, 2 uc_load, 3 uc_store, 4 wt_store, others unsupported.
- cache_req_addr_i  in  paddr_width_p  request address.
- cache_req_data_i  in  64  store dword.
- cache_req_metadata_v_i  in  1  metadata valid.
- cache_req_metadata_way_i  in  way_w  replacement way.
- mem_cmd_v_o  out  1  memory command valid.
- mem_cmd_ready_i  in  1  memory ready.
- mem_cmd_write_o  out  1  1 store, 0 read.
- mem_cmd_addr_o  out  paddr_width_p  command address.
- mem_cmd_data_o  out  64  store data.
- mem_resp_v_i  in  1  response valid.
- mem_resp_data_i  in  block_width_p  response data.
- mem_resp_yumi_o  out  1  response consumed.
- data_mem_pkt_v_o  out  1  data packet valid.
- data_mem_pkt_yumi_i  in  1  data packet consumed.
- data_mem_pkt_uncached_o  out  1  1 uncached data, 0 block write.
- data_mem_pkt_index_o  out  index_w  data packet index.
- data_mem_pkt_way_o  out  way_w  data packet way.
- data_mem_pkt_data_o  out  block_width_p  data packet payload.
- tag_mem_pkt_v_o  out  1  tag packet valid.
- tag_mem_pkt_yumi_i  in  1  tag packet consumed.
- tag_mem_pkt_index_o  out  index_w  tag packet index.
- tag_mem_pkt_way_o  out  way_w  tag packet way.
- tag_mem_pkt_tag_o  out  tag_w  tag packet tag.
- stat_mem_pkt_v_o  out  1  stat packet valid (set_clear).
- stat_mem_pkt_yumi_i  in  1  stat packet consumed.
- stat_mem_pkt_index_o  out  index_w  stat packet index.
- stat_mem_pkt_way_o  out  way_w  stat packet way.
- cache_req_complete_o  out  1  one-cycle completion pulse.
- busy_o  out  1  state != READY.

Function
REQ-006 States SHALL be READY, WAIT_META, SEND_CMD, WAIT_RESP, FILL, DONE.
REQ-007 In READY, cache_req_yumi_o SHALL equal cache_req_v_i. On accept, the FSM SHALL register type, addr and data.
- miss types SHALL go to WAIT_META.
- uc_load, uc_store and wt_store SHALL go to SEND_CMD.
- unsupported types SHALL go to DONE.
REQ-008 WAIT_META SHALL capture the way on cache_req_metadata_v_i and go to SEND_CMD the same edge. Metadata arriving in READY SHALL be ignored.
REQ-009 mem_cmd_v_o SHALL be high only in SEND_CMD.
- Misses SHALL issue a read at addr with the low offset_w bits zeroed.
- Uncached loads SHALL issue a read at the exact addr.
- Stores SHALL issue a write with data.
- On mem_cmd_v_o & mem_cmd_ready_i, stores SHALL go to DONE and loads to WAIT_RESP.
REQ-010 In WAIT_RESP, mem_resp_yumi_o SHALL equal mem_resp_v_i. The FSM SHALL latch the response and go to FILL; mem_resp_yumi_o SHALL be 0 in all other states.
REQ-011 On FILL entry, misses SHALL assert data, tag and stat packets simultaneously with the addr index and tag and the captured way.
REQ-012 On FILL entry, uc_load SHALL assert only the data packet, with uncached_o=1 and the addressed dword in bits [63:0].
REQ-013 Each packet SHALL drop its valid the cycle after its own yumi, independently of the others. FILL SHALL exit to DONE once all issued packets are consumed, including same-cycle yumis.
REQ-014 A yumi without the matching valid SHALL be ignored.
REQ-015 DONE SHALL pulse cache_req_complete_o for exactly one cycle, then return to READY. A new request SHALL NOT be accepted in DONE.
REQ-016 All packet fields SHALL hold stable while their valid is high.

Reset
REQ-017 reset_n_i low SHALL force READY immediately, asynchronously, including mid-operation.
REQ-018 On reset, all valid, yumi and complete outputs, and busy_o, SHALL be 0.
REQ-019 On reset, all latched data, addr and way registers SHALL be 0.
REQ-020 After reset deasserts, the first cache_req_v_i SHALL be accepted the same cycle.

Verification
REQ-021 miss_load to addr 0x8000_1040, metadata way 3, ready and response immediate -> yumi at cycle 0; command at addr 0x8000_1040 with write=0; three packets with index 0x01 and way 3; complete pulses one cycle.
REQ-022 Data yumi 2 cycles before tag and stat yumis -> complete only after the last yumi; data_v low from the cycle after its yumi.
REQ-023 uc_store addr 0x1000, data 0xDEAD_BEEF, ready delayed 5 cycles -> cmd_v held stable 6 cycles; no fill packets; complete the cycle after acceptance.
REQ-024 uc_load at 0x1008 with response word 1 = 0x1234 -> data packet with uncached_o=1 and data[63:0]=0x1234.
REQ-025 reset_n_i dropped in WAIT_RESP -> all outputs 0 asynchronously; a later response is ignored; a new request is accepted.
REQ-026 Unsupported type 7 -> complete pulse 1 cycle after acceptance; no mem_cmd_v_o.

Source files
------------

// File: rtl/bp_cache_fill_responder_if.sv
// Cache-side request, memory command/response and fill-packet bundle for the fill responder.
// master: the responder FSM; slave: cache front end, memory and tag/data/stat arrays.
interface bp_cache_fill_responder_if #(
  parameter int paddr_width_p = 40,
  parameter int sets_p        = 64,
  parameter int assoc_p       = 8,
  parameter int block_width_p = 512
);
  localparam int index_w  = $clog2(sets_p);
  localparam int way_w    = $clog2(assoc_p);
  localparam int offset_w = $clog2(block_width_p / 8);
  localparam int tag_w    = paddr_width_p - index_w - offset_w;

  logic                     cache_req_v_i;
  logic                     cache_req_yumi_o;
  logic [2:0]               cache_req_type_i;
  logic [paddr_width_p-1:0] cache_req_addr_i;
  logic [63:0]              cache_req_data_i;
  logic                     cache_req_metadata_v_i;
  logic [way_w-1:0]         cache_req_metadata_way_i;

  logic                     mem_cmd_v_o;
  logic                     mem_cmd_ready_i;
  logic                     mem_cmd_write_o;
  logic [paddr_width_p-1:0] mem_cmd_addr_o;
  logic [63:0]              mem_cmd_data_o;
  logic                     mem_resp_v_i;
  logic [block_width_p-1:0] mem_resp_data_i;
  logic                     mem_resp_yumi_o;

  logic                     data_mem_pkt_v_o;
  logic                     data_mem_pkt_yumi_i;
  logic                     data_mem_pkt_uncached_o;
  logic [index_w-1:0]       data_mem_pkt_index_o;
  logic [way_w-1:0]         data_mem_pkt_way_o;
  logic [block_width_p-1:0] data_mem_pkt_data_o;

  logic                     tag_mem_pkt_v_o;
  logic                     tag_mem_pkt_yumi_i;
  logic [index_w-1:0]       tag_mem_pkt_index_o;
  logic [way_w-1:0]         tag_mem_pkt_way_o;
  logic [tag_w-1:0]         tag_mem_pkt_tag_o;

  logic                     stat_mem_pkt_v_o;
  logic                     stat_mem_pkt_yumi_i;
  logic [index_w-1:0]       stat_mem_pkt_index_o;
  logic [way_w-1:0]         stat_mem_pkt_way_o;

  logic                     cache_req_complete_o;
  logic                     busy_o;

  modport master (
    input  cache_req_v_i, cache_req_type_i, cache_req_addr_i, cache_req_data_i,
    input  cache_req_metadata_v_i, cache_req_metadata_way_i,
    input  mem_cmd_ready_i, mem_resp_v_i, mem_resp_data_i,
    input  data_mem_pkt_yumi_i, tag_mem_pkt_yumi_i, stat_mem_pkt_yumi_i,
    output cache_req_yumi_o,
    output mem_cmd_v_o, mem_cmd_write_o, mem_cmd_addr_o, mem_cmd_data_o, mem_resp_yumi_o,
    output data_mem_pkt_v_o, data_mem_pkt_uncached_o, data_mem_pkt_index_o,
    output data_mem_pkt_way_o, data_mem_pkt_data_o,
    output tag_mem_pkt_v_o, tag_mem_pkt_index_o, tag_mem_pkt_way_o, tag_mem_pkt_tag_o,
    output stat_mem_pkt_v_o, stat_mem_pkt_index_o, stat_mem_pkt_way_o,
    output cache_req_complete_o, busy_o
  );

  modport slave (
    output cache_req_v_i, cache_req_type_i, cache_req_addr_i, cache_req_data_i,
    output cache_req_metadata_v_i, cache_req_metadata_way_i,
    output mem_cmd_ready_i, mem_resp_v_i, mem_resp_data_i,
    output data_mem_pkt_yumi_i, tag_mem_pkt_yumi_i, stat_mem_pkt_yumi_i,
    input  cache_req_yumi_o,
    input  mem_cmd_v_o, mem_cmd_write_o, mem_cmd_addr_o, mem_cmd_data_o, mem_resp_yumi_o,
    input  data_mem_pkt_v_o, data_mem_pkt_uncached_o, data_mem_pkt_index_o,
    input  data_mem_pkt_way_o, data_mem_pkt_data_o,
    input  tag_mem_pkt_v_o, tag_mem_pkt_index_o, tag_mem_pkt_way_o, tag_mem_pkt_tag_o,
    input  stat_mem_pkt_v_o, stat_mem_pkt_index_o, stat_mem_pkt_way_o,
    input  cache_req_complete_o, busy_o
  );
endinterface

// File: rtl/bp_cache_fill_responder.sv
// Serves one cache miss/uncached/write-through request at a time: memory command, response, fill packets.
// Request accepted same cycle in READY; each stage waits on its own ready/valid/yumi, packets retire independently.
module bp_cache_fill_responder #(
  parameter int paddr_width_p = 40,
  parameter int sets_p        = 64,
  parameter int assoc_p       = 8,
  parameter int block_width_p = 512
) (
  input logic                       clk_i,
  input logic                       reset_n_i,
  bp_cache_fill_responder_if.master bus
);
  localparam int index_w  = $clog2(sets_p);
  localparam int way_w    = $clog2(assoc_p);
  localparam int offset_w = $clog2(block_width_p / 8);
  localparam int tag_w    = paddr_width_p - index_w - offset_w;
  localparam int dword_w  = offset_w - 3;

  localparam logic [2:0] req_miss_load  = 3'd0;
  localparam logic [2:0] req_miss_store = 3'd1;
  localparam logic [2:0] req_uc_load    = 3'd2;
  localparam logic [2:0] req_uc_store   = 3'd3;
  localparam logic [2:0] req_wt_store   = 3'd4;

  typedef enum logic [2:0] {
    S_READY,
    S_WAIT_META,
    S_SEND_CMD,
    S_WAIT_RESP,
    S_FILL,
    S_DONE
  } state_e;

  state_e                   state;
  logic [2:0]               req_type;
  logic [paddr_width_p-1:0] req_addr;
  logic [63:0]              req_data;
  logic [way_w-1:0]         req_way;
  logic [block_width_p-1:0] resp_data;
  logic                     data_v;
  logic                     tag_v;
  logic                     stat_v;

  logic                     is_miss;
  logic                     is_store;
  logic                     is_uc_load;
  logic                     fill_done;
  logic [dword_w-1:0]       dword_sel;
  logic [63:0]              uc_dword;

  assign is_miss    = (req_type == req_miss_load) || (req_type == req_miss_store);
  assign is_store   = (req_type == req_uc_store) || (req_type == req_wt_store);
  assign is_uc_load = (req_type == req_uc_load);

  assign dword_sel = req_addr[offset_w-1:3];
  assign uc_dword  = resp_data[{dword_sel, 6'b000} +: 64];

  // A packet that is not outstanding, or is consumed this cycle, no longer holds FILL open.
  assign fill_done = (!data_v || bus.data_mem_pkt_yumi_i)
                  && (!tag_v  || bus.tag_mem_pkt_yumi_i)
                  && (!stat_v || bus.stat_mem_pkt_yumi_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= S_READY;
      req_type  <= '0;
      req_addr  <= '0;
      req_data  <= '0;
      req_way   <= '0;
      resp_data <= '0;
      data_v    <= 1'b0;
      tag_v     <= 1'b0;
      stat_v    <= 1'b0;
    end else begin
      case (state)
        S_READY: begin
          if (bus.cache_req_v_i) begin
            req_type <= bus.cache_req_type_i;
            req_addr <= bus.cache_req_addr_i;
            req_data <= bus.cache_req_data_i;
            case (bus.cache_req_type_i)
              req_miss_load, req_miss_store:            state <= S_WAIT_META;
              req_uc_load, req_uc_store, req_wt_store:  state <= S_SEND_CMD;
              default:                                  state <= S_DONE;
            endcase
          end
        end
        S_WAIT_META: begin
          if (bus.cache_req_metadata_v_i) begin
            req_way <= bus.cache_req_metadata_way_i;
            state   <= S_SEND_CMD;
          end
        end
        S_SEND_CMD: begin
          if (bus.mem_cmd_ready_i) begin
            state <= is_store ? S_DONE : S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          if (bus.mem_resp_v_i) begin
            resp_data <= bus.mem_resp_data_i;
            data_v    <= 1'b1;
            tag_v     <= is_miss;
            stat_v    <= is_miss;
            state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (bus.data_mem_pkt_yumi_i) data_v <= 1'b0;
          if (bus.tag_mem_pkt_yumi_i)  tag_v  <= 1'b0;
          if (bus.stat_mem_pkt_yumi_i) stat_v <= 1'b0;
          if (fill_done) state <= S_DONE;
        end
        S_DONE: state <= S_READY;
        default: state <= S_READY;
      endcase
    end
  end

  // Acceptance is gated by reset so a request held during reset is never acknowledged.
  assign bus.cache_req_yumi_o = reset_n_i && (state == S_READY) && bus.cache_req_v_i;

  assign bus.mem_cmd_v_o     = (state == S_SEND_CMD);
  assign bus.mem_cmd_write_o = is_store;
  assign bus.mem_cmd_addr_o  = is_miss ? {req_addr[paddr_width_p-1:offset_w], {offset_w{1'b0}}}
                                       : req_addr;
  assign bus.mem_cmd_data_o  = req_data;
  assign bus.mem_resp_yumi_o = (state == S_WAIT_RESP) && bus.mem_resp_v_i;

  assign bus.data_mem_pkt_v_o        = data_v;
  assign bus.data_mem_pkt_uncached_o = is_uc_load;
  assign bus.data_mem_pkt_index_o    = req_addr[offset_w +: index_w];
  assign bus.data_mem_pkt_way_o      = req_way;
  assign bus.data_mem_pkt_data_o     = is_uc_load ? {{(block_width_p-64){1'b0}}, uc_dword}
                                                  : resp_data;

  assign bus.tag_mem_pkt_v_o     = tag_v;
  assign bus.tag_mem_pkt_index_o = req_addr[offset_w +: index_w];
  assign bus.tag_mem_pkt_way_o   = req_way;
  assign bus.tag_mem_pkt_tag_o   = req_addr[paddr_width_p-1 -: tag_w];

  assign bus.stat_mem_pkt_v_o     = stat_v;
  assign bus.stat_mem_pkt_index_o = req_addr[offset_w +: index_w];
  assign bus.stat_mem_pkt_way_o   = req_way;

  assign bus.cache_req_complete_o = (state == S_DONE);
  assign bus.busy_o               = (state != S_READY);
endmodule

// File: tb/tb_bp_cache_fill_responder.sv
// Directed bench for bp_cache_fill_responder: literal per-step checks plus a request-level model
// that predicts command and fill-packet contents from address arithmetic.
module tb_bp_cache_fill_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  bp_cache_fill_responder_if bus ();
  bp_cache_fill_responder dut (.clk_i(clk), .reset_n_i(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Model of the request in flight, derived from type/address/data only.
  logic         exp_cmd_v, exp_write, exp_pkt, exp_tagstat, exp_unc;
  logic [39:0]  exp_addr;
  logic [63:0]  exp_cdata;
  logic [5:0]   exp_index;
  logic [2:0]   exp_way;
  logic [27:0]  exp_tag;
  logic [511:0] exp_data;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic set_expect(input logic [2:0] t, input logic [39:0] a, input logic [63:0] d,
                            input logic [2:0] w, input logic [511:0] resp);
    logic [511:0] sh;
    exp_cmd_v   = (t <= 3'd4);
    exp_write   = (t == 3'd3) || (t == 3'd4);
    exp_tagstat = (t <= 3'd1);
    exp_unc     = (t == 3'd2);
    exp_pkt     = exp_tagstat || exp_unc;
    exp_addr    = exp_tagstat ? (a / 64) * 64 : a;
    exp_cdata   = d;
    exp_index   = 6'((a / 64) % 64);
    exp_tag     = 28'(a / 4096);
    exp_way     = w;
    sh          = resp >> (64 * ((a % 64) / 8));
    exp_data    = exp_unc ? {448'd0, sh[63:0]} : resp;
  endtask

  always @(negedge clk) begin
    if (bus.mem_cmd_v_o) begin
      check("cmd_allowed", 512'(bus.mem_cmd_v_o), 512'(exp_cmd_v));
      check("cmd_write", 512'(bus.mem_cmd_write_o), 512'(exp_write));
      check("cmd_addr", 512'(bus.mem_cmd_addr_o), 512'(exp_addr));
      if (exp_write) check("cmd_data", 512'(bus.mem_cmd_data_o), 512'(exp_cdata));
    end
    if (bus.data_mem_pkt_v_o) begin
      check("data_pkt_allowed", 512'(bus.data_mem_pkt_v_o), 512'(exp_pkt));
      check("data_pkt_uncached", 512'(bus.data_mem_pkt_uncached_o), 512'(exp_unc));
      check("data_pkt_data", bus.data_mem_pkt_data_o, exp_data);
      if (exp_tagstat) begin
        check("data_pkt_index", 512'(bus.data_mem_pkt_index_o), 512'(exp_index));
        check("data_pkt_way", 512'(bus.data_mem_pkt_way_o), 512'(exp_way));
      end
    end
    if (bus.tag_mem_pkt_v_o) begin
      check("tag_pkt_allowed", 512'(bus.tag_mem_pkt_v_o), 512'(exp_tagstat));
      check("tag_pkt_index", 512'(bus.tag_mem_pkt_index_o), 512'(exp_index));
      check("tag_pkt_way", 512'(bus.tag_mem_pkt_way_o), 512'(exp_way));
      check("tag_pkt_tag", 512'(bus.tag_mem_pkt_tag_o), 512'(exp_tag));
    end
    if (bus.stat_mem_pkt_v_o) begin
      check("stat_pkt_allowed", 512'(bus.stat_mem_pkt_v_o), 512'(exp_tagstat));
      check("stat_pkt_index", 512'(bus.stat_mem_pkt_index_o), 512'(exp_index));
      check("stat_pkt_way", 512'(bus.stat_mem_pkt_way_o), 512'(exp_way));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [2:0] t, input logic [39:0] a, input logic [63:0] d);
    bus.cache_req_v_i    = 1'b1;
    bus.cache_req_type_i = t;
    bus.cache_req_addr_i = a;
    bus.cache_req_data_i = d;
  endtask

  task automatic outputs_idle(input string tag);
    check({tag, "_busy"}, 512'(bus.busy_o), 512'(0));
    check({tag, "_cmd_v"}, 512'(bus.mem_cmd_v_o), 512'(0));
    check({tag, "_resp_yumi"}, 512'(bus.mem_resp_yumi_o), 512'(0));
    check({tag, "_data_v"}, 512'(bus.data_mem_pkt_v_o), 512'(0));
    check({tag, "_tag_v"}, 512'(bus.tag_mem_pkt_v_o), 512'(0));
    check({tag, "_stat_v"}, 512'(bus.stat_mem_pkt_v_o), 512'(0));
    check({tag, "_complete"}, 512'(bus.cache_req_complete_o), 512'(0));
    check({tag, "_cmd_addr"}, 512'(bus.mem_cmd_addr_o), 512'(0));
    check({tag, "_pkt_way"}, 512'(bus.data_mem_pkt_way_o), 512'(0));
    check({tag, "_pkt_data"}, bus.data_mem_pkt_data_o, 512'(0));
  endtask

  logic [511:0] blk;

  initial begin
    bus.cache_req_v_i = 1'b0;          bus.cache_req_type_i = '0;
    bus.cache_req_addr_i = '0;         bus.cache_req_data_i = '0;
    bus.cache_req_metadata_v_i = 1'b0; bus.cache_req_metadata_way_i = '0;
    bus.mem_cmd_ready_i = 1'b0;        bus.mem_resp_v_i = 1'b0;
    bus.mem_resp_data_i = '0;          bus.data_mem_pkt_yumi_i = 1'b0;
    bus.tag_mem_pkt_yumi_i = 1'b0;     bus.stat_mem_pkt_yumi_i = 1'b0;
    exp_cmd_v = 0; exp_write = 0; exp_pkt = 0; exp_tagstat = 0; exp_unc = 0;
    exp_addr = '0; exp_cdata = '0; exp_index = '0; exp_way = '0; exp_tag = '0; exp_data = '0;

    #3;
    outputs_idle("rst");
    check("rst_yumi", 512'(bus.cache_req_yumi_o), 512'(0));

    // Miss load, way 3; metadata offered in READY with a different way must be ignored.
    for (int i = 0; i < 8; i++) blk[i*64 +: 64] = 64'hF00D_0000_0000_0000 + 64'(i) * 64'h1111;
    @(posedge clk); #1;
    rst_n = 1'b1;
    request(3'd0, 40'h00_8000_1040, 64'h0);
    bus.cache_req_metadata_v_i = 1'b1; bus.cache_req_metadata_way_i = 3'd5;
    bus.mem_cmd_ready_i = 1'b1;
    set_expect(3'd0, 40'h00_8000_1040, 64'h0, 3'd3, blk);
    #1 check("t1_yumi_first_cycle", 512'(bus.cache_req_yumi_o), 512'(1));
    tick();
    bus.cache_req_v_i = 1'b0; bus.cache_req_metadata_way_i = 3'd3;
    #1 check("t1_busy", 512'(bus.busy_o), 512'(1));
    check("t1_no_cmd_in_meta", 512'(bus.mem_cmd_v_o), 512'(0));
    tick();
    bus.cache_req_metadata_v_i = 1'b0;
    #1 check("t1_cmd_v", 512'(bus.mem_cmd_v_o), 512'(1));
    check("t1_cmd_addr", 512'(bus.mem_cmd_addr_o), 512'(40'h00_8000_1040));
    check("t1_cmd_write", 512'(bus.mem_cmd_write_o), 512'(0));
    tick();
    bus.mem_resp_v_i = 1'b1; bus.mem_resp_data_i = blk;
    #1 check("t1_resp_yumi", 512'(bus.mem_resp_yumi_o), 512'(1));
    tick();
    bus.mem_resp_v_i = 1'b0;
    #1 check("t1_pkts_v", 512'({bus.data_mem_pkt_v_o, bus.tag_mem_pkt_v_o, bus.stat_mem_pkt_v_o}), 512'(3'b111));
    check("t1_index", 512'(bus.tag_mem_pkt_index_o), 512'(6'h01));
    check("t1_way", 512'(bus.stat_mem_pkt_way_o), 512'(3'd3));
    check("t1_tag", 512'(bus.tag_mem_pkt_tag_o), 512'(28'h0080001));
    bus.data_mem_pkt_yumi_i = 1'b1; bus.tag_mem_pkt_yumi_i = 1'b1; bus.stat_mem_pkt_yumi_i = 1'b1;
    tick();
    bus.data_mem_pkt_yumi_i = 1'b0; bus.tag_mem_pkt_yumi_i = 1'b0; bus.stat_mem_pkt_yumi_i = 1'b0;
    #1 check("t1_complete", 512'(bus.cache_req_complete_o), 512'(1));
    check("t1_pkts_dropped", 512'({bus.data_mem_pkt_v_o, bus.tag_mem_pkt_v_o, bus.stat_mem_pkt_v_o}), 512'(0));
    tick();
    #1 check("t1_complete_one_cycle", 512'(bus.cache_req_complete_o), 512'(0));
    check("t1_idle", 512'(bus.busy_o), 512'(0));

    // Miss store with staggered yumis: data first, tag and stat two cycles later.
    for (int i = 0; i < 8; i++) blk[i*64 +: 64] = 64'hABCD_0000_0000_0000 ^ (64'(i) << 8);
    request(3'd1, 40'h12_3456_7FC8, 64'h55);
    set_expect(3'd1, 40'h12_3456_7FC8, 64'h55, 3'd6, blk);
    tick();
    bus.cache_req_v_i = 1'b0;
    tick();
    #1 check("t2_wait_meta_no_cmd", 512'(bus.mem_cmd_v_o), 512'(0));
    bus.cache_req_metadata_v_i = 1'b1; bus.cache_req_metadata_way_i = 3'd6;
    tick();
    bus.cache_req_metadata_v_i = 1'b0;
    #1 check("t2_cmd_addr_aligned", 512'(bus.mem_cmd_addr_o), 512'(40'h12_3456_7FC0));
    tick();
    #1 check("t2_no_resp_yumi", 512'(bus.mem_resp_yumi_o), 512'(0));
    tick();
    bus.mem_resp_v_i = 1'b1; bus.mem_resp_data_i = blk;
    tick();
    bus.mem_resp_v_i = 1'b0;
    bus.data_mem_pkt_yumi_i = 1'b1;
    #1 check("t2_index", 512'(bus.data_mem_pkt_index_o), 512'(6'h3F));
    tick();
    #1 check("t2_data_v_dropped", 512'(bus.data_mem_pkt_v_o), 512'(0));
    check("t2_tag_stat_held", 512'({bus.tag_mem_pkt_v_o, bus.stat_mem_pkt_v_o}), 512'(2'b11));
    check("t2_no_early_complete", 512'(bus.cache_req_complete_o), 512'(0));
    tick();
    bus.data_mem_pkt_yumi_i = 1'b0;
    #1 check("t2_still_filling", 512'({bus.busy_o, bus.cache_req_complete_o, bus.tag_mem_pkt_v_o}), 512'(3'b101));
    bus.tag_mem_pkt_yumi_i = 1'b1; bus.stat_mem_pkt_yumi_i = 1'b1;
    tick();
    bus.tag_mem_pkt_yumi_i = 1'b0; bus.stat_mem_pkt_yumi_i = 1'b0;
    #1 check("t2_complete", 512'(bus.cache_req_complete_o), 512'(1));
    tick();

    // Uncached store with memory ready held off for five cycles.
    bus.mem_cmd_ready_i = 1'b0;
    request(3'd3, 40'h00_0000_1000, 64'hDEAD_BEEF);
    set_expect(3'd3, 40'h00_0000_1000, 64'hDEAD_BEEF, 3'd0, '0);
    tick();
    bus.cache_req_v_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1 check("t3_cmd_v_held", 512'(bus.mem_cmd_v_o), 512'(1));
      if (i == 5) bus.mem_cmd_ready_i = 1'b1;
      tick();
    end
    bus.mem_cmd_ready_i = 1'b0;
    #1 check("t3_complete", 512'({bus.cache_req_complete_o, bus.mem_cmd_v_o}), 512'(2'b10));
    check("t3_no_pkts", 512'({bus.data_mem_pkt_v_o, bus.tag_mem_pkt_v_o, bus.stat_mem_pkt_v_o}), 512'(0));
    tick();

    // Uncached load of dword 1.
    for (int i = 0; i < 8; i++) blk[i*64 +: 64] = 64'hA000 + 64'(i);
    blk[127:64] = 64'h1234;
    bus.mem_cmd_ready_i = 1'b1;
    request(3'd2, 40'h00_0000_1008, 64'h0);
    set_expect(3'd2, 40'h00_0000_1008, 64'h0, 3'd0, blk);
    tick();
    bus.cache_req_v_i = 1'b0;
    #1 check("t4_cmd_addr_exact", 512'(bus.mem_cmd_addr_o), 512'(40'h00_0000_1008));
    tick();
    bus.mem_resp_v_i = 1'b1; bus.mem_resp_data_i = blk;
    tick();
    bus.mem_resp_v_i = 1'b0;
    #1 check("t4_only_data_pkt", 512'({bus.data_mem_pkt_v_o, bus.tag_mem_pkt_v_o, bus.stat_mem_pkt_v_o}), 512'(3'b100));
    check("t4_uncached", 512'(bus.data_mem_pkt_uncached_o), 512'(1));
    check("t4_dword", bus.data_mem_pkt_data_o, 512'(64'h1234));
    bus.data_mem_pkt_yumi_i = 1'b1;
    tick();
    bus.data_mem_pkt_yumi_i = 1'b0;
    #1 check("t4_complete", 512'(bus.cache_req_complete_o), 512'(1));
    tick();

    // Reset while waiting for a response.
    request(3'd0, 40'h00_4000_0080, 64'h0);
    bus.cache_req_metadata_v_i = 1'b1; bus.cache_req_metadata_way_i = 3'd2;
    set_expect(3'd0, 40'h00_4000_0080, 64'h0, 3'd2, blk);
    tick();
    bus.cache_req_v_i = 1'b0;
    tick();
    bus.cache_req_metadata_v_i = 1'b0;
    tick();
    #1 check("t5_in_wait_resp", 512'({bus.busy_o, bus.mem_cmd_v_o}), 512'(2'b10));
    rst_n = 1'b0;
    #1 outputs_idle("t5_async_rst");
    bus.mem_resp_v_i = 1'b1; bus.mem_resp_data_i = blk;
    request(3'd4, 40'h02_0000_0018, 64'h0123_4567_89AB_CDEF);
    #1 check("t5_rst_no_yumi", 512'({bus.cache_req_yumi_o, bus.mem_resp_yumi_o}), 512'(0));
    tick();
    rst_n = 1'b1;
    set_expect(3'd4, 40'h02_0000_0018, 64'h0123_4567_89AB_CDEF, 3'd0, '0);
    #1 check("t5_accept_after_rst", 512'(bus.cache_req_yumi_o), 512'(1));
    check("t5_resp_ignored", 512'(bus.mem_resp_yumi_o), 512'(0));
    tick();
    bus.cache_req_v_i = 1'b0;
    #1 check("t5_wt_cmd", 512'({bus.mem_cmd_v_o, bus.mem_cmd_write_o, bus.mem_resp_yumi_o}), 512'(3'b110));
    tick();
    bus.mem_resp_v_i = 1'b0;
    #1 check("t5_complete", 512'({bus.cache_req_complete_o, bus.data_mem_pkt_v_o}), 512'(2'b10));
    tick();

    // Unsupported type completes without a command; no acceptance while in DONE.
    request(3'd7, 40'h00_0000_0055, 64'h0);
    set_expect(3'd7, 40'h00_0000_0055, 64'h0, 3'd0, '0);
    tick();
    request(3'd3, 40'h00_0000_3000, 64'hCAFE);
    #1 check("t6_complete", 512'({bus.cache_req_complete_o, bus.mem_cmd_v_o}), 512'(2'b10));
    check("t6_no_accept_in_done", 512'(bus.cache_req_yumi_o), 512'(0));
    tick();
    set_expect(3'd3, 40'h00_0000_3000, 64'hCAFE, 3'd0, '0);
    #1 check("t6_accept_after_done", 512'({bus.cache_req_yumi_o, bus.cache_req_complete_o}), 512'(2'b10));
    tick();
    bus.cache_req_v_i = 1'b0;
    #1 check("t6_store_cmd", 512'(bus.mem_cmd_v_o), 512'(1));
    tick();
    #1 check("t6_store_complete", 512'(bus.cache_req_complete_o), 512'(1));
    tick();
    #1 check("t6_idle", 512'({bus.busy_o, bus.cache_req_complete_o}), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
